branch_resolve_controller: RTL
==============================

BRANCH_RESOLVE_CONTROLLER -- requirements
Module: branch_resolve_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port BranchEQ_ID  input  1  beq decoded in ID.
REQ-005 SHALL have port BranchNE_ID  input  1  bne decoded in ID.
REQ-006 SHALL have ports Rs_ID, Rt_ID  input  5 each  source registers of the ID instruction.
REQ-007 SHALL have ports RegWrite_EX, MemRead_EX  input  1 each  EX-stage control.
REQ-008 SHALL have port WriteReg_EX  input  5  EX-stage destination register.
REQ-009 SHALL have ports RegWrite_MEM, MemRead_MEM  input  1 each  MEM-stage control.
REQ-010 SHALL have port WriteReg_MEM  input  5  MEM-stage destination register.
REQ-011 SHALL have port Zero  input  1  equality result of the ID-stage comparator (1 = operands equal).
REQ-012 SHALL have port Stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-013 SHALL have ports ForwardA_ID, ForwardB_ID  output  1 each  comparator operand select: 1 = MEM ALU result, 0 = register file.
REQ-014 SHALL have port PCSrc  output  1  select branch target.
REQ-015 SHALL have port Flush_IF  output  1  clear IF/ID on the next edge.
REQ-016 SHALL have ports BranchCnt, TakenCnt, StallCnt  output  CNT_WIDTH each  statistics.

Function
REQ-017 SHALL define Branch = BranchEQ_ID | BranchNE_ID and Taken = (BranchEQ_ID & Zero) | (BranchNE_ID & ~Zero).
REQ-018 SHALL define a match on Rs or Rt against a destination register only when that destination is nonzero and the stage's RegWrite is 1.
REQ-019 SHALL compute the stall need N in IDLE: 2 if MemRead_EX and EX match; else 1 if EX match (ALU) or (MemRead_MEM and MEM match); else 0.
REQ-020 SHALL implement states IDLE and STALL plus a 2-bit down-counter cnt.
REQ-021 In IDLE with Branch=1 and N=0, SHALL resolve in the same cycle: Stall=0, PCSrc=Flush_IF=Taken; stay IDLE.
REQ-022 In IDLE with Branch=1 and N>0, SHALL assert Stall=1, PCSrc=Flush_IF=0, load cnt=N-1, go to STALL.
REQ-023 In STALL with cnt>0, SHALL assert Stall=1, decrement cnt, and stay in STALL.
REQ-024 In STALL with cnt=0, SHALL assert Stall=0, resolve per REQ-021, and return to IDLE.
REQ-025 SHALL ignore hazard inputs while in STALL; stall length is fixed at entry.
REQ-026 SHALL drive ForwardA_ID = RegWrite_MEM & ~MemRead_MEM & (WriteReg_MEM==Rs_ID) & (Rs_ID!=0); ForwardB_ID is the same using Rt_ID; both combinational in every state.
REQ-027 SHALL keep Stall, PCSrc, Flush_IF at 0 when Branch=0 in IDLE.
REQ-028 SHALL increment BranchCnt on each resolve cycle, TakenCnt on each taken resolve, and StallCnt on each cycle with Stall=1; all counters saturate at all-ones.
REQ-029 SHALL never assert PCSrc and Stall in the same cycle.

Reset
REQ-030 On reset low, SHALL immediately force state=IDLE, cnt=0, and all counters to 0; Stall, PCSrc, Flush_IF SHALL be 0 while reset is low.
REQ-031 Reset asserted mid-STALL SHALL abandon the pending branch; after release the FSM re-evaluates from IDLE.

Verification
REQ-032 beq, Rs=5, Rt=6, no hazards, Zero=1 -> same cycle PCSrc=1, Flush_IF=1, Stall=0; BranchCnt=1, TakenCnt=1.
REQ-033 bne, Rs=8, EX ALU writes $8 -> cycle0 Stall=1; cycle1 (MEM now writes $8, ForwardA_ID=1) Zero=1 gives PCSrc=0; StallCnt=1.
REQ-034 beq, Rt=9, EX lw writes $9 -> Stall=1 for 2 cycles, resolve on cycle 2 with ForwardB_ID=0; StallCnt=2.
REQ-035 beq, Rs=0, EX writes $0 with RegWrite=1 -> no stall, ForwardA_ID=0.
REQ-036 Reset low during the second stall cycle of a load hazard -> Stall drops immediately, counters read 0, no PCSrc pulse.
REQ-037 Force 2^CNT_WIDTH+3 taken branches -> BranchCnt and TakenCnt hold all-ones.

Source files
------------

// File: rtl/branch_resolve_controller.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_controller
//  Description : ID-stage branch resolution with hazard stalls, comparator
//                operand forwarding and saturating statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 BranchEQ_ID,
    input  logic                 BranchNE_ID,
    input  logic [4:0]           Rs_ID,
    input  logic [4:0]           Rt_ID,
    input  logic                 RegWrite_EX,
    input  logic                 MemRead_EX,
    input  logic [4:0]           WriteReg_EX,
    input  logic                 RegWrite_MEM,
    input  logic                 MemRead_MEM,
    input  logic [4:0]           WriteReg_MEM,
    input  logic                 Zero,
    output logic                 Stall,
    output logic                 ForwardA_ID,
    output logic                 ForwardB_ID,
    output logic                 PCSrc,
    output logic                 Flush_IF,
    output logic [CNT_WIDTH-1:0] BranchCnt,
    output logic [CNT_WIDTH-1:0] TakenCnt,
    output logic [CNT_WIDTH-1:0] StallCnt
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t r_state, w_stateNext;
    logic [1:0] r_cnt, w_cntNext;
    logic [CNT_WIDTH-1:0] r_branchCnt, r_takenCnt, r_stallCnt;

    logic w_branch, w_taken;
    logic w_exMatch, w_memMatch;
    logic [1:0] w_need;
    logic w_stall, w_resolve;

    assign w_branch = BranchEQ_ID | BranchNE_ID;
    assign w_taken  = (BranchEQ_ID & Zero) | (BranchNE_ID & ~Zero);

    // Register $0 is never a real producer, so it can never create a hazard.
    assign w_exMatch  = RegWrite_EX && (WriteReg_EX != 5'd0) &&
                        ((WriteReg_EX == Rs_ID) || (WriteReg_EX == Rt_ID));
    assign w_memMatch = RegWrite_MEM && (WriteReg_MEM != 5'd0) &&
                        ((WriteReg_MEM == Rs_ID) || (WriteReg_MEM == Rt_ID));

    always_comb begin
        w_need = 2'd0;
        if (MemRead_EX && w_exMatch)
            w_need = 2'd2;
        else if (w_exMatch || (MemRead_MEM && w_memMatch))
            w_need = 2'd1;
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_stall     = 1'b0;
        w_resolve   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_branch) begin
                    if (w_need == 2'd0) begin
                        w_resolve = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_cntNext   = w_need - 2'd1;
                        w_stateNext = STALL;
                    end
                end
            end
            STALL: begin
                if (r_cnt != 2'd0) begin
                    w_stall   = 1'b1;
                    w_cntNext = r_cnt - 2'd1;
                end else begin
                    w_resolve   = 1'b1;
                    w_stateNext = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branchCnt <= '0;
            r_takenCnt  <= '0;
            r_stallCnt  <= '0;
        end else begin
            if (w_resolve && (r_branchCnt != c_CNT_MAX))
                r_branchCnt <= r_branchCnt + 1'b1;
            if (w_resolve && w_taken && (r_takenCnt != c_CNT_MAX))
                r_takenCnt <= r_takenCnt + 1'b1;
            if (w_stall && (r_stallCnt != c_CNT_MAX))
                r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    // Control outputs are gated so nothing escapes while reset is held low.
    assign Stall    = w_stall & reset;
    assign PCSrc    = w_resolve & w_taken & reset;
    assign Flush_IF = w_resolve & w_taken & reset;

    assign ForwardA_ID = RegWrite_MEM & ~MemRead_MEM &
                         (WriteReg_MEM == Rs_ID) & (Rs_ID != 5'd0);
    assign ForwardB_ID = RegWrite_MEM & ~MemRead_MEM &
                         (WriteReg_MEM == Rt_ID) & (Rt_ID != 5'd0);

    assign BranchCnt = r_branchCnt;
    assign TakenCnt  = r_takenCnt;
    assign StallCnt  = r_stallCnt;

endmodule
`default_nettype wire
